// File: rtl/sipo_buf_param.sv
// Parametrised serial-in/parallel-out capture buffer for the DUFT scan path.
// Build option: define SIPO_MSB_FIRST_EN to shift MSB-first instead of LSB-first.
module sipo_buf_param #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 64,
    parameter int CHAINS = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAINS-1:0] sin,
    output logic [WORD_W-1:0] pout,
    input  logic              val_op,
    input  logic [1:0]        op,
    input  logic [ADDR_W:0]   scan_words,
    output logic              op_ack,
    output logic              op_commit,
    output logic              scaning,
    output logic [ADDR_W:0]   wcount,
    output logic              ovf
);
    localparam int K  = WORD_W / CHAINS;
    localparam int BW = (K > 1) ? $clog2(K) : 1;
    localparam logic [BW-1:0]   K_LAST  = BW'(K - 1);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] OP_SCAN  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_READ, S_COMMIT} state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] sr_next;
    logic [BW-1:0]     bcnt;
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W:0]   words_q;
    logic [ADDR_W:0]   wdone;
    logic              rd_hit;
    logic [WORD_W-1:0] rd_q;
    logic [WORD_W-1:0] mem [DEPTH];

    logic word_done;
    logic last_word;
    logic wr_en;

    generate
        if (K == 1) begin : g_one_beat
            assign sr_next = sin;
        end else begin : g_shift
`ifdef SIPO_MSB_FIRST_EN
            assign sr_next = {sr[WORD_W-CHAINS-1:0], sin};
`else
            assign sr_next = {sin, sr[WORD_W-1:CHAINS]};
`endif
        end
    endgenerate

    assign word_done = (state == S_SCAN) && (bcnt == K_LAST);
    assign last_word = word_done && (wdone == words_q - 1'b1);
    // A word completing with the buffer full is dropped, not wrapped.
    assign wr_en     = word_done && (wcount != DEPTH_C);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr[ADDR_W-1:0]] <= sr_next;
        rd_q <= mem[rptr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= OP_SCAN;
            sr        <= '0;
            bcnt      <= '0;
            wptr      <= '0;
            rptr      <= '0;
            words_q   <= '0;
            wdone     <= '0;
            rd_hit    <= 1'b0;
            pout      <= '0;
            op_ack    <= 1'b0;
            op_commit <= 1'b0;
            scaning   <= 1'b0;
            wcount    <= '0;
            ovf       <= 1'b0;
        end else begin
            op_ack    <= 1'b0;
            op_commit <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (val_op) begin
                        op_ack <= 1'b1;
                        op_q   <= op;
                        rd_hit <= (rptr < wcount);
                        if (op == OP_SCAN && scan_words != '0) begin
                            state   <= S_SCAN;
                            scaning <= 1'b1;
                            words_q <= scan_words;
                            wdone   <= '0;
                            bcnt    <= '0;
                        end else begin
                            // READ state doubles as the single ack cycle for
                            // CLEAR, reserved and zero-length SCAN.
                            state <= S_READ;
                        end
                    end
                end
                S_SCAN: begin
                    sr <= sr_next;
                    if (word_done) begin
                        bcnt  <= '0;
                        wdone <= wdone + 1'b1;
                        if (wr_en) begin
                            wptr   <= wptr + 1'b1;
                            wcount <= wcount + 1'b1;
                        end else begin
                            ovf <= 1'b1;
                        end
                        if (last_word) begin
                            state     <= S_COMMIT;
                            scaning   <= 1'b0;
                            op_commit <= 1'b1;
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                S_READ: begin
                    state     <= S_COMMIT;
                    op_commit <= 1'b1;
                    case (op_q)
                        OP_READ: begin
                            if (rd_hit) begin
                                pout <= rd_q;
                                rptr <= rptr + 1'b1;
                            end else begin
                                pout <= '0;
                            end
                        end
                        OP_CLEAR: begin
                            wptr   <= '0;
                            rptr   <= '0;
                            wcount <= '0;
                            ovf    <= 1'b0;
                            pout   <= '0;
                        end
                        default: ;
                    endcase
                end
                S_COMMIT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sipo_buf_param.sv
// Directed bench for sipo_buf_param: CHAINS=1/DEPTH=4 and CHAINS=4/DEPTH=64 instances.
module tb_sipo_buf_param;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Instance A: WORD_W=32, CHAINS=1, DEPTH=4
    logic [0:0]  sin_a;
    logic [31:0] pout_a;
    logic        val_a, ack_a, com_a, scn_a, ovf_a;
    logic [1:0]  op_a;
    logic [2:0]  sw_a, wcnt_a;

    // Instance B: WORD_W=32, CHAINS=4, DEPTH=64
    logic [3:0]  sin_b;
    logic [31:0] pout_b;
    logic        val_b, ack_b, com_b, scn_b, ovf_b;
    logic [1:0]  op_b;
    logic [6:0]  sw_b, wcnt_b;

    sipo_buf_param #(.WORD_W(32), .DEPTH(4), .CHAINS(1)) dut_a (
        .clk(clk), .reset(reset), .sin(sin_a), .pout(pout_a),
        .val_op(val_a), .op(op_a), .scan_words(sw_a),
        .op_ack(ack_a), .op_commit(com_a), .scaning(scn_a),
        .wcount(wcnt_a), .ovf(ovf_a)
    );

    sipo_buf_param #(.WORD_W(32), .DEPTH(64), .CHAINS(4)) dut_b (
        .clk(clk), .reset(reset), .sin(sin_b), .pout(pout_b),
        .val_op(val_b), .op(op_b), .scan_words(sw_b),
        .op_ack(ack_b), .op_commit(com_b), .scaning(scn_b),
        .wcount(wcnt_b), .ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stored word for a stream whose beat g carries s[g*c +: c].
    function automatic logic [31:0] exp_word(input logic [31:0] s, input int c);
        logic [31:0] r;
        r = s;
`ifdef SIPO_MSB_FIRST_EN
        for (int g = 0; g < 32 / c; g++)
            for (int b = 0; b < c; b++)
                r[(32 / c - 1 - g) * c + b] = s[g * c + b];
`endif
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic go_a(input logic [1:0] o, input logic [2:0] sw);
        val_a = 1'b1; op_a = o; sw_a = sw;
        @(posedge clk);
        @(negedge clk);
        val_a = 1'b0;
    endtask

    task automatic go_b(input logic [1:0] o, input logic [6:0] sw);
        val_b = 1'b1; op_b = o; sw_b = sw;
        @(posedge clk);
        @(negedge clk);
        val_b = 1'b0;
    endtask

    task automatic feed_a(input logic [31:0] w, input int beats);
        for (int i = 0; i < beats; i++) begin
            sin_a = w[i];
            @(negedge clk);
        end
    endtask

    task automatic feed_b(input logic [31:0] w);
        for (int i = 0; i < 8; i++) begin
            sin_b = w[i*4 +: 4];
            @(negedge clk);
        end
    endtask

    task automatic read_a(input string tag, input logic [31:0] exp);
        go_a(2'b01, 3'd0);
        chk({tag, "_ack"}, {31'd0, ack_a}, 32'd1);
        @(negedge clk);
        chk({tag, "_commit"}, {31'd0, com_a}, 32'd1);
        chk({tag, "_pout"}, pout_a, exp);
        @(negedge clk);
    endtask

    task automatic read_b(input string tag, input logic [31:0] exp);
        go_b(2'b01, 7'd0);
        chk({tag, "_ack"}, {31'd0, ack_b}, 32'd1);
        @(negedge clk);
        chk({tag, "_commit"}, {31'd0, com_b}, 32'd1);
        chk({tag, "_pout"}, pout_b, exp);
        @(negedge clk);
    endtask

    task automatic scan1_a(input string tag, input logic [31:0] w, input logic [2:0] wc_exp);
        go_a(2'b00, 3'd1);
        chk({tag, "_ack"}, {31'd0, ack_a}, 32'd1);
        chk({tag, "_scaning"}, {31'd0, scn_a}, 32'd1);
        feed_a(w, 32);
        chk({tag, "_commit"}, {31'd0, com_a}, 32'd1);
        chk({tag, "_wcount"}, {29'd0, wcnt_a}, {29'd0, wc_exp});
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        sin_a = '0; val_a = 1'b0; op_a = 2'b00; sw_a = '0;
        sin_b = '0; val_b = 1'b0; op_b = 2'b00; sw_b = '0;
        @(negedge clk);
        chk("rst_pout", pout_a, 32'd0);
        chk("rst_ack", {31'd0, ack_a}, 32'd0);
        chk("rst_commit", {31'd0, com_a}, 32'd0);
        chk("rst_scaning", {31'd0, scn_a}, 32'd0);
        chk("rst_wcount", {29'd0, wcnt_a}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // CHAINS=4: two words, nibble per beat
        go_b(2'b00, 7'd2);
        chk("b_scan_ack", {31'd0, ack_b}, 32'd1);
        chk("b_scaning", {31'd0, scn_b}, 32'd1);
        feed_b(32'h0123_4567);
        chk("b_mid_commit", {31'd0, com_b}, 32'd0);
        feed_b(32'h89AB_CDEF);
        chk("b_scan_commit", {31'd0, com_b}, 32'd1);
        chk("b_wcount", {25'd0, wcnt_b}, 32'd2);
        @(negedge clk);
        read_b("b_rd0", exp_word(32'h0123_4567, 4));
        read_b("b_rd1", exp_word(32'h89AB_CDEF, 4));
        read_b("b_rd2", 32'd0);

        // CHAINS=1: one word, commit after 32 beats
        scan1_a("a_scan", 32'hDEAD_BEEF, 3'd1);

        // READ with a val_op pulse during READ/COMMIT
        go_a(2'b01, 3'd0);
        chk("a_rd_ack", {31'd0, ack_a}, 32'd1);
        chk("a_rd_early", {31'd0, com_a}, 32'd0);
        val_a = 1'b1; op_a = 2'b10;
        @(negedge clk);
        val_a = 1'b0;
        chk("a_rd_commit", {31'd0, com_a}, 32'd1);
        chk("a_rd_pout", pout_a, exp_word(32'hDEAD_BEEF, 1));
        @(negedge clk);
        chk("a_busy_noack", {31'd0, ack_a}, 32'd0);
        chk("a_busy_wcount", {29'd0, wcnt_a}, 32'd1);

        // Reserved opcode
        go_a(2'b11, 3'd0);
        chk("a_rsv_ack", {31'd0, ack_a}, 32'd1);
        @(negedge clk);
        chk("a_rsv_commit", {31'd0, com_a}, 32'd1);
        chk("a_rsv_pout", pout_a, exp_word(32'hDEAD_BEEF, 1));
        chk("a_rsv_wcount", {29'd0, wcnt_a}, 32'd1);
        @(negedge clk);

        read_a("a_rd_empty", 32'd0);

        // Zero-length SCAN
        go_a(2'b00, 3'd0);
        chk("a_z_ack", {31'd0, ack_a}, 32'd1);
        chk("a_z_scaning", {31'd0, scn_a}, 32'd0);
        @(negedge clk);
        chk("a_z_commit", {31'd0, com_a}, 32'd1);
        chk("a_z_wcount", {29'd0, wcnt_a}, 32'd1);
        @(negedge clk);

        // Overflow: 6 words into 3 free slots, CLEAR pulsed mid-scan
        go_a(2'b00, 3'd6);
        chk("a_ov_ack", {31'd0, ack_a}, 32'd1);
        feed_a(32'h1111_0001, 32);
        val_a = 1'b1; op_a = 2'b10;
        feed_a(32'hA5A5_5A5A, 32);
        chk("a_ov_noack", {31'd0, ack_a}, 32'd0);
        val_a = 1'b0;
        feed_a(32'h0F0F_F0F0, 32);
        chk("a_ov_full", {29'd0, wcnt_a}, 32'd4);
        chk("a_ov_notyet", {31'd0, ovf_a}, 32'd0);
        feed_a(32'hFFFF_FFFF, 32);
        chk("a_ov_set", {31'd0, ovf_a}, 32'd1);
        feed_a(32'h1234_5678, 32);
        chk("a_ov_early", {31'd0, com_a}, 32'd0);
        chk("a_ov_scaning", {31'd0, scn_a}, 32'd1);
        feed_a(32'h8765_4321, 32);
        chk("a_ov_commit", {31'd0, com_a}, 32'd1);
        chk("a_ov_wcount", {29'd0, wcnt_a}, 32'd4);
        chk("a_ov_sticky", {31'd0, ovf_a}, 32'd1);
        @(negedge clk);
        read_a("a_ov_rd0", exp_word(32'h1111_0001, 1));
        read_a("a_ov_rd1", exp_word(32'hA5A5_5A5A, 1));

        // CLEAR
        go_a(2'b10, 3'd0);
        chk("a_clr_ack", {31'd0, ack_a}, 32'd1);
        @(negedge clk);
        chk("a_clr_commit", {31'd0, com_a}, 32'd1);
        chk("a_clr_wcount", {29'd0, wcnt_a}, 32'd0);
        chk("a_clr_ovf", {31'd0, ovf_a}, 32'd0);
        chk("a_clr_pout", pout_a, 32'd0);
        @(negedge clk);

        scan1_a("a_s2", 32'hCAFE_F00D, 3'd1);
        read_a("a_s2_rd", exp_word(32'hCAFE_F00D, 1));

        // Asynchronous reset 10 beats into a SCAN
        go_a(2'b00, 3'd1);
        feed_a(32'hFFFF_FFFF, 10);
        #2 reset = 1'b0;
        #1;
        chk("a_ar_pout", pout_a, 32'd0);
        chk("a_ar_wcount", {29'd0, wcnt_a}, 32'd0);
        chk("a_ar_scaning", {31'd0, scn_a}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        scan1_a("a_s3", 32'h0000_FFFF, 3'd1);
        read_a("a_s3_rd", exp_word(32'h0000_FFFF, 1));

        // Bit order: first sampled bit is 1, rest 0
        scan1_a("a_ord", 32'h0000_0001, 3'd2);
`ifdef SIPO_MSB_FIRST_EN
        read_a("a_ord_rd", 32'h8000_0000);
`else
        read_a("a_ord_rd", 32'h0000_0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
